// File: rtl/icache_fill_if.sv
// Fetch-side and main-memory-side signal bundle for icache_fill.
// slave is the cache's view; master is the fetch stage plus memory.
interface icache_fill_if;
  logic        req;
  logic [15:0] addr;
  logic        inv;
  logic [15:0] rdata;
  logic        stall;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;

  modport master (
    output req, addr, inv, mem_rdata, mem_valid,
    input  rdata, stall, mem_en, mem_addr
  );

  modport slave (
    input  req, addr, inv, mem_rdata, mem_valid,
    output rdata, stall, mem_en, mem_addr
  );
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped read-only instruction cache with an 8-word miss-fill FSM.
// Optional access/miss counters are enabled by defining ICACHE_STATS_EN.
module icache_fill #(
  parameter int unsigned NUM_SETS = 64,
  parameter int unsigned MEM_LAT  = 4
) (
  input  logic          clk,
  input  logic          rst,
  icache_fill_if.slave  bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]   acc_cnt,
  output logic [15:0]   miss_cnt
`endif
);

  localparam int unsigned IB = $clog2(NUM_SETS);
  localparam int unsigned TW = 12 - IB;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]          state;
  logic [TW-1:0]       tag_l;
  logic [IB-1:0]       idx_l;
  logic [2:0]          issue_cnt;
  logic [2:0]          ret_cnt;
  logic                issue_done;
  logic [MEM_LAT-1:0]  live;

  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] valid_nxt;
  logic [TW-1:0]       tag_store [NUM_SETS];
  logic [15:0]         data [NUM_SETS*8];

  logic [2:0]          offset;
  logic [IB-1:0]       index;
  logic [TW-1:0]       tag;
  logic [IB+2:0]       rd_ptr;
  logic                hit;
  logic                miss_start;
  logic                accept;
  logic                last_ret;
  logic                mem_en_i;
  logic                unused_addr0;

  assign offset       = bus.addr[3:1];
  assign index        = bus.addr[4+IB-1:4];
  assign tag          = bus.addr[15:4+IB];
  assign rd_ptr       = {index, offset};
  assign unused_addr0 = bus.addr[0];

  assign hit        = bus.req & valid[index] & (tag_store[index] == tag);
  assign miss_start = (state == IDLE) & bus.req & ~hit;

  // Returns land exactly MEM_LAT cycles after their issue; a return is taken
  // only if its issue is still tracked, so reset drops in-flight words.
  assign accept   = (state == FILL) & bus.mem_valid & live[MEM_LAT-1];
  assign last_ret = accept & (ret_cnt == 3'd7);

  assign mem_en_i     = (state == FILL) & ~issue_done;
  assign bus.mem_en   = mem_en_i;
  assign bus.mem_addr = mem_en_i ? {tag_l, idx_l, issue_cnt, 1'b0} : '0;
  assign bus.stall    = (state == FILL) | (bus.req & ~hit);
  assign bus.rdata    = ((state == IDLE) && hit) ? data[rd_ptr] : '0;

  always_comb begin
    valid_nxt = valid;
    if (state == IDLE) begin
      if (bus.inv)
        valid_nxt = '0;
      if (miss_start)
        valid_nxt[index] = 1'b0;
    end else begin
      if (bus.inv) begin
        valid_nxt        = '0;
        valid_nxt[idx_l] = valid[idx_l];
      end
      if (last_ret)
        valid_nxt[idx_l] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tag_l      <= '0;
      idx_l      <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      issue_done <= 1'b0;
      live       <= '0;
      valid      <= '0;
    end else begin
      live[0] <= mem_en_i;
      for (int unsigned i = 1; i < MEM_LAT; i++)
        live[i] <= live[i-1];
      valid <= valid_nxt;
      case (state)
        IDLE: begin
          if (miss_start) begin
            state      <= FILL;
            tag_l      <= tag;
            idx_l      <= index;
            issue_cnt  <= '0;
            ret_cnt    <= '0;
            issue_done <= 1'b0;
          end
        end
        FILL: begin
          if (mem_en_i) begin
            issue_cnt <= issue_cnt + 3'd1;
            if (issue_cnt == 3'd7)
              issue_done <= 1'b1;
          end
          if (accept)
            ret_cnt <= ret_cnt + 3'd1;
          if (last_ret)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && accept)
      data[{idx_l, ret_cnt}] <= bus.mem_rdata;
    if (!rst && last_ret)
      tag_store[idx_l] <= tag_l;
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == IDLE) && bus.req && (acc_cnt != '1))
        acc_cnt <= acc_cnt + 16'd1;
      if (miss_start && (miss_cnt != '1))
        miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill.sv
// Directed self-checking bench for icache_fill with a fixed-latency memory model.
module tb_icache_fill;
  localparam int unsigned MEM_LAT = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  icache_fill_if bus();

`ifdef ICACHE_STATS_EN
  logic [15:0] acc_cnt;
  logic [15:0] miss_cnt;
`endif

  icache_fill #(.NUM_SETS(64), .MEM_LAT(MEM_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef ICACHE_STATS_EN
    ,
    .acc_cnt  (acc_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word at byte address a; block 0x0040 holds A000..A007.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return 16'hA000 + ((a - 16'h0040) >> 1);
  endfunction

  logic        hv [MEM_LAT];
  logic [15:0] ha [MEM_LAT];

  initial begin
    for (int i = 0; i < int'(MEM_LAT); i++) begin
      hv[i] = 1'b0;
      ha[i] = 16'h0;
    end
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 16'h0;
    forever begin
      @(negedge clk);
      bus.mem_valid = hv[MEM_LAT-1];
      bus.mem_rdata = hv[MEM_LAT-1] ? mem_word(ha[MEM_LAT-1]) : 16'h0;
      for (int i = int'(MEM_LAT) - 1; i > 0; i--) begin
        hv[i] = hv[i-1];
        ha[i] = ha[i-1];
      end
      hv[0] = bus.mem_en;
      ha[0] = bus.mem_addr;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_fill(input int inv_at, output int cyc, output int ens);
    cyc = 1;
    ens = 0;
    for (int i = 1; i < 40; i++) begin
      step();
      bus.inv = (i == inv_at);
      #1;
      if (!bus.stall) break;
      cyc++;
      if (bus.mem_en) ens++;
    end
    bus.inv = 1'b0;
  endtask

  task automatic fill(input logic [15:0] a, input int inv_at, input logic [15:0] exp, input string tag);
    int cyc;
    int ens;
    bus.req  = 1'b1;
    bus.addr = a;
    #1;
    chk({tag, "_miss"}, 16'(bus.stall), 16'd1);
    wait_fill(inv_at, cyc, ens);
    chk({tag, "_penalty"}, cyc[15:0], 16'd13);
    chk({tag, "_issues"}, ens[15:0], 16'd8);
    chk({tag, "_data"}, bus.rdata, exp);
  endtask

  initial begin
    int cyc;
    int ens;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus.req  = 1'b0;
    bus.addr = 16'h0;
    bus.inv  = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_stall", 16'(bus.stall), 16'd0);
    chk("rst_mem_en", 16'(bus.mem_en), 16'd0);
    chk("rst_mem_addr", bus.mem_addr, 16'h0000);
    chk("rst_rdata", bus.rdata, 16'h0000);

    // Cold miss at 0x0046: miss cycle, 8 issues, 4 latency cycles.
    step();
    bus.req  = 1'b1;
    bus.addr = 16'h0046;
    #1;
    chk("cold_miss_stall", 16'(bus.stall), 16'd1);
    chk("cold_miss_en", 16'(bus.mem_en), 16'd0);
    for (int i = 1; i < 13; i++) begin
      step();
      #1;
      chk("cold_stall", 16'(bus.stall), 16'd1);
      chk("cold_mem_en", 16'(bus.mem_en), (i <= 8) ? 16'd1 : 16'd0);
      chk("cold_mem_addr", bus.mem_addr, (i <= 8) ? 16'(16'h0040 + 2 * (i - 1)) : 16'h0000);
    end
    step();
    #1;
    chk("cold_done_stall", 16'(bus.stall), 16'd0);
    chk("cold_done_rdata", bus.rdata, 16'hA003);

    // Remaining words of the block hit with no memory traffic.
    for (int k = 0; k < 8; k++) begin
      if (k == 3) continue;
      step();
      bus.addr = 16'(16'h0040 + 2 * k);
      #1;
      chk("seq_rdata", bus.rdata, 16'(16'hA000 + k));
      chk("seq_stall", 16'(bus.stall), 16'd0);
      chk("seq_mem_en", 16'(bus.mem_en), 16'd0);
    end
    step();
    bus.req = 1'b0;
    #1;
`ifdef ICACHE_STATS_EN
    chk("stats_acc", acc_cnt, 16'd9);
    chk("stats_miss", miss_cnt, 16'd1);
`endif

    // Conflict on index 4: tag 1 evicts tag 0, then tag 0 returns.
    step();
    fill(16'h0440, 0, 16'hA200, "evict_t1");
    step();
    fill(16'h0040, 0, 16'hA000, "evict_t0");

    // Invalidate while filling line 5: line 5 survives, line 4 is lost.
    step();
    fill(16'h0050, 5, 16'hA008, "inv_fill");
    step();
    bus.addr = 16'h0052;
    #1;
    chk("inv_line5_hit", bus.rdata, 16'hA009);
    chk("inv_line5_stall", 16'(bus.stall), 16'd0);
    step();
    fill(16'h0040, 0, 16'hA000, "inv_line4");

    // Reset on the third fill cycle; stale returns must not be absorbed.
    step();
    bus.addr = 16'h0060;
    #1;
    chk("rstmid_miss", 16'(bus.stall), 16'd1);
    step();
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rstmid_f3_en", 16'(bus.mem_en), 16'd1);
    chk("rstmid_f3_addr", bus.mem_addr, 16'h0064);
    step();
    rst = 1'b0;
    #1;
    chk("rstmid_en_drop", 16'(bus.mem_en), 16'd0);
    chk("rstmid_restall", 16'(bus.stall), 16'd1);
    wait_fill(0, cyc, ens);
    chk("rstmid_penalty", cyc[15:0], 16'd13);
    chk("rstmid_issues", ens[15:0], 16'd8);
    for (int k = 0; k < 8; k++) begin
      step();
      bus.addr = 16'(16'h0060 + 2 * k);
      #1;
      chk("rstmid_word", bus.rdata, 16'(16'hA010 + k));
      chk("rstmid_hit", 16'(bus.stall), 16'd0);
    end

    step();
    bus.req = 1'b0;
    #1;
    chk("idle_stall", 16'(bus.stall), 16'd0);
    chk("idle_rdata", bus.rdata, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
